// File: rtl/secded_enc_pipe.sv
// secded_enc_pipe: two-stage (39,32) SECDED encoder with elastic handshake, fault injection and counters.
// S1 captures the word and computes parity[5:0]; S2 adds overall parity, applies injected flips, and registers the outputs.
module secded_enc_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       inj_mode,
    input  logic [5:0]       inj_pos_a,
    input  logic [5:0]       inj_pos_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [6:0]       out_parity,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] out_cnt,
    output logic [CNT_W-1:0] inj_cnt
);
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic [5:0]       s1_par_q, s1_par_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [5:0]       s1_pos_a_q, s1_pos_a_d;
    logic [5:0]       s1_pos_b_q, s1_pos_b_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [6:0]       out_par_q, out_par_d;
    logic             out_inj_q, out_inj_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;
    logic [38:1]      cw;
    logic [5:0]       par_in;
    logic [38:0]      code;
    logic [38:0]      flip_mask;
    logic             s1_adv, in_hs, out_hs, s2_load;

    // Power-of-two positions hold check bits; data bit index = pos - 1 - (powers of two below pos).
    for (genvar g = 1; g <= 38; g++) begin : g_map
        if ((g & (g - 1)) == 0) begin : g_chk
            assign cw[g] = 1'b0;
        end else begin : g_dat
            assign cw[g] = in_data[g - 1 - $clog2(g)];
        end
    end

    always_comb begin
        par_in = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                par_in[k] = par_in[k] ^ (cw[p] & p[k]);
        s1_adv     = !out_valid_q || out_ready;
        in_ready   = !s1_valid_q || s1_adv;
        in_hs      = in_valid && in_ready;
        out_hs     = out_valid_q && out_ready;
        s2_load    = s1_adv && s1_valid_q;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_data_d  = in_hs ? in_data : s1_data_q;
        s1_par_d   = in_hs ? par_in : s1_par_q;
        s1_mode_d  = in_hs ? inj_mode : s1_mode_q;
        s1_pos_a_d = in_hs ? inj_pos_a : s1_pos_a_q;
        s1_pos_b_d = in_hs ? inj_pos_b : s1_pos_b_q;
        // Flips are applied after overall parity; positions above 38 shift out of the mask, equal positions OR to one flip.
        code       = {^{s1_data_q, s1_par_q}, s1_par_q, s1_data_q};
        flip_mask  = ((s1_mode_q == 2'b01 || s1_mode_q == 2'b10) ? (39'd1 << s1_pos_a_q) : 39'd0)
                   | ((s1_mode_q == 2'b10) ? (39'd1 << s1_pos_b_q) : 39'd0);
        out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
        out_data_d  = s2_load ? code[31:0] ^ flip_mask[31:0] : out_data_q;
        out_par_d   = s2_load ? code[38:32] ^ flip_mask[38:32] : out_par_q;
        out_inj_d   = s2_load ? |flip_mask : out_inj_q;
        out_cnt_d   = clr_cnt ? '0 : (out_hs && !(&out_cnt_q)) ? out_cnt_q + CNT_W'(1) : out_cnt_q;
        inj_cnt_d   = clr_cnt ? '0 : (out_hs && out_inj_q && !(&inj_cnt_q)) ? inj_cnt_q + CNT_W'(1) : inj_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_par_q    <= '0;
            s1_mode_q   <= '0;
            s1_pos_a_q  <= '0;
            s1_pos_b_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= '0;
            out_inj_q   <= 1'b0;
            out_cnt_q   <= '0;
            inj_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_par_q    <= s1_par_d;
            s1_mode_q   <= s1_mode_d;
            s1_pos_a_q  <= s1_pos_a_d;
            s1_pos_b_q  <= s1_pos_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_inj_q   <= out_inj_d;
            out_cnt_q   <= out_cnt_d;
            inj_cnt_q   <= inj_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_par_q;
    assign out_cnt    = out_cnt_q;
    assign inj_cnt    = inj_cnt_q;
endmodule

// File: tb/tb_secded_enc_pipe.sv
// tb_secded_enc_pipe: vector table plus scoreboard bench for secded_enc_pipe, with a second CNT_W=2 instance for saturation.
module tb_secded_enc_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  inj_mode = '0;
    logic [5:0]  inj_pos_a = '0, inj_pos_b = '0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_data, out_data2;
    logic [6:0]  out_parity, out_parity2;
    logic [15:0] out_cnt, inj_cnt;
    logic [1:0]  out_cnt2, inj_cnt2;

    typedef struct { logic [31:0] d; logic [6:0] p; logic inj; } exp_t;
    typedef struct { logic [31:0] din; logic [1:0] m; logic [5:0] a; logic [5:0] b; exp_t e; } vec_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int m_cnt = 0, m_inj = 0, m_cnt2 = 0, m_inj2 = 0;

    secded_enc_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_mode(inj_mode), .inj_pos_a(inj_pos_a), .inj_pos_b(inj_pos_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_parity(out_parity), .clr_cnt(clr_cnt),
        .out_cnt(out_cnt), .inj_cnt(inj_cnt));

    secded_enc_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .inj_mode(inj_mode), .inj_pos_a(inj_pos_a), .inj_pos_b(inj_pos_b), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_parity(out_parity2), .clr_cnt(clr_cnt),
        .out_cnt(out_cnt2), .inj_cnt(inj_cnt2));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, want);
        end
    endtask

    // Parity[5:0] is the XOR of the codeword positions of all set data bits.
    function automatic exp_t model(input logic [31:0] d, input logic [1:0] m, input logic [5:0] a, input logic [5:0] b);
        exp_t r;
        logic [38:0] v;
        logic [6:0] p;
        int pos;
        p = '0;
        pos = 2;
        for (int i = 0; i < 32; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) p[5:0] = p[5:0] ^ 6'(pos);
        end
        p[6] = ^d ^ ^p[5:0];
        v = {p, d};
        if ((m == 2'b01 || m == 2'b10) && a < 39) v[a] = ~v[a];
        if (m == 2'b10 && b < 39 && b != a) v[b] = ~v[b];
        r.d = v[31:0];
        r.p = v[38:32];
        r.inj = (v != {p, d});
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] d, input logic [1:0] m, input logic [5:0] a, input logic [5:0] b);
        vec_t v;
        v.din = d; v.m = m; v.a = a; v.b = b;
        v.e = model(d, m, a, b);
        return v;
    endfunction

    task automatic send(input vec_t v);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = v.din; inj_mode = v.m; inj_pos_a = v.a; inj_pos_b = v.b;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready %0b expected 1", in_ready);
        end else q.push_back(v.e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 64'(q.size()), 64'd0);
        #3;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic hs, ei;
        #2;
        if (!rst_n) begin
            m_cnt = 0; m_inj = 0; m_cnt2 = 0; m_inj2 = 0;
            chk("reset_out_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("out_cnt", 64'(out_cnt), 64'(m_cnt));
            chk("inj_cnt", 64'(inj_cnt), 64'(m_inj));
            chk("out_cnt_w2", 64'(out_cnt2), 64'(m_cnt2));
            chk("inj_cnt_w2", 64'(inj_cnt2), 64'(m_inj2));
            hs = out_valid && out_ready;
            ei = 1'b0;
            if (hs) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word data %0h parity %0h expected none", out_data, out_parity);
                end else begin
                    e = q.pop_front();
                    ei = e.inj;
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_parity", 64'(out_parity), 64'(e.p));
                end
            end
            if (clr_cnt) begin
                m_cnt = 0; m_inj = 0; m_cnt2 = 0; m_inj2 = 0;
            end else if (hs) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
                if (ei && m_inj < 65535) m_inj++;
                if (ei && m_inj2 < 3) m_inj2++;
            end
        end
    end

    initial begin
        vec_t tv[10];
        vec_t sv[5];
        logic [31:0] hold_d;
        logic [6:0] hold_p;
        int n;
        tv[0].din = 32'h1; tv[0].m = 2'b00; tv[0].a = 6'd0; tv[0].b = 6'd0;
        tv[0].e.d = 32'h1; tv[0].e.p = 7'b1000011; tv[0].e.inj = 1'b0;
        tv[1].din = 32'h2; tv[1].m = 2'b01; tv[1].a = 6'd38; tv[1].b = 6'd0;
        tv[1].e.d = 32'h2; tv[1].e.p = 7'b0000101; tv[1].e.inj = 1'b1;
        tv[2].din = 32'h0; tv[2].m = 2'b10; tv[2].a = 6'd0; tv[2].b = 6'd1;
        tv[2].e.d = 32'h3; tv[2].e.p = 7'b0000000; tv[2].e.inj = 1'b1;
        tv[3] = mk(32'hDEADBEEF, 2'b11, 6'd5, 6'd6);
        tv[4] = mk(32'hFFFFFFFF, 2'b10, 6'd7, 6'd7);
        tv[5] = mk(32'h12345678, 2'b01, 6'd45, 6'd0);
        tv[6] = mk(32'hA5A5A5A5, 2'b10, 6'd32, 6'd50);
        tv[7] = mk(32'h80000000, 2'b01, 6'd31, 6'd0);
        tv[8] = mk($urandom, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 45)), 6'($urandom_range(0, 45)));
        tv[9] = mk($urandom, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 45)), 6'($urandom_range(0, 45)));
        for (int i = 0; i < 5; i++)
            sv[i] = mk(32'hC0DE0000 + 32'(i * 7), 2'(i % 2), 6'(i * 8), 6'd0);

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_parity", 64'(out_parity), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        send(tv[0]);
        chk("latency_s1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 chk("latency_s2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 chk("first_out_cnt", 64'(out_cnt), 64'd1);
        chk("first_drained", 64'(out_valid), 64'd0);

        for (int i = 1; i < 10; i++) send(tv[i]);
        drain();

        @(negedge clk) clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        @(negedge clk) out_ready = 1'b0;
        send(sv[0]);
        send(sv[1]);
        @(negedge clk);
        #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        hold_d = out_data;
        hold_p = out_parity;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("stall_in_ready_hold", 64'(in_ready), 64'd0);
            chk("stall_data_stable", 64'(out_data), 64'(hold_d));
            chk("stall_parity_stable", 64'(out_parity), 64'(hold_p));
        end
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(sv[i]);
        drain();
        chk("stream_out_cnt", 64'(out_cnt), 64'd5);

        @(negedge clk) out_ready = 1'b0;
        send(tv[3]);
        send(tv[4]);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1 chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("async_rst_inj_cnt", 64'(inj_cnt), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h5A5A0001; inj_mode = 2'b00; inj_pos_a = '0; inj_pos_b = '0;
        #1 chk("first_edge_in_ready", 64'(in_ready), 64'd1);
        q.push_back(model(32'h5A5A0001, 2'b00, 6'd0, 6'd0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1 chk("no_stale_word", 64'(out_valid), 64'd0);
        drain();
        repeat (3) @(negedge clk);
        #1 chk("post_reset_idle", 64'(out_valid), 64'd0);

        @(negedge clk) clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(tv[5 + i]);
        drain();
        chk("sat_out_cnt_w2", 64'(out_cnt2), 64'd3);
        chk("sat_out_cnt_w16", 64'(out_cnt), 64'd5);

        @(negedge clk) out_ready = 1'b0;
        send(tv[1]);
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!out_valid && n < 10);
        chk("clr_setup_valid", 64'(out_valid), 64'd1);
        clr_cnt = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        chk("clr_prio_out_cnt", 64'(out_cnt), 64'd0);
        chk("clr_prio_inj_cnt", 64'(inj_cnt), 64'd0);
        chk("clr_prio_out_cnt_w2", 64'(out_cnt2), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/secded_enc_pipe.md
SECDED_ENC_PIPE -- requirements
Module: secded_enc_pipe

Interface
- REQ-001: Parameter CNT_W, 16: width of the transfer and injection counters.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: in_valid  input  1  upstream word valid.
- REQ-005: in_ready  output  1  block accepts the word this cycle.
- REQ-006: in_data  input  32  raw data word.
- REQ-007: inj_mode  input  2  sampled with the word: 00 none, 01 single flip, 10 double flip, 11 none.
- REQ-008: inj_pos_a  input  6  first flip position in the 39-bit codeword.
- REQ-009: inj_pos_b  input  6  second flip position, used only in mode 10.
- REQ-010: out_valid  output  1  encoded word valid.
- REQ-011: out_ready  input  1  downstream corrector/memory accepts the word.
- REQ-012: out_data  output  32  data part of the codeword.
- REQ-013: out_parity  output  7  check bits, matching the correction_detection parity input.
- REQ-014: clr_cnt  input  1  synchronous clear of both counters.
- REQ-015: out_cnt  output  CNT_W  output handshakes since reset or clear, saturating.
- REQ-016: inj_cnt  output  CNT_W  output handshakes carrying at least one injected flip, saturating.

Function
- REQ-017: Data bit i SHALL occupy the (i+1)-th non-power-of-two position of a 1-indexed codeword (3,5,6,7,9,...,38).
- REQ-018: parity[k], k=0..5, SHALL be the XOR of all data bits whose position has bit k set.
- REQ-019: parity[6] SHALL be the XOR of all 32 data bits and parity[5:0] (even overall parity).
- REQ-020: Injection indices: 0..31 = out_data[0..31], 32..38 = out_parity[0..6]; an index above 38 flips nothing.
- REQ-021: Injection SHALL be applied after parity[6] is computed, so flips never alter the computed check bits.
- REQ-022: Mode 10 with inj_pos_a == inj_pos_b SHALL flip that bit once (treated as single).
- REQ-023: Pipeline: two register stages, S1 (capture data and injection controls, compute parity[5:0]) and S2 (parity[6], injection, output registers).
- REQ-024: in_ready SHALL equal (!S1.valid || S1 advances this cycle); S1 advances when (!S2.valid || out_ready).
- REQ-025: Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
- REQ-026: Latency SHALL be 2 cycles from input handshake to out_valid with out_ready held high; throughput one word per cycle.
- REQ-027: While out_valid && !out_ready, out_data and out_parity SHALL hold stable; no word is dropped or duplicated.
- REQ-028: At most 2 words in flight; with out_ready low, in_ready SHALL fall after the second accepted word.
- REQ-029: Counters SHALL increment on an output handshake and saturate at 2^CNT_W-1; inj_cnt increments only if at least one bit was flipped.
- REQ-030: clr_cnt SHALL set both counters to 0 next cycle and take priority over a simultaneous increment.

Reset
- REQ-031: On rst_n low, immediately: both stage valids 0, out_valid 0, out_data 0, out_parity 0, out_cnt 0, inj_cnt 0.
- REQ-032: in_ready SHALL read 1 during and after reset.
- REQ-033: Words in flight at reset assertion SHALL be discarded; none is emitted after release.
- REQ-034: The first input handshake SHALL be possible on the first rising edge after rst_n goes high.

Verification
- REQ-035: in_data 0x00000001, mode 00, out_ready 1 -> 2 cycles later out_parity 7'b1000011, out_data 0x1, out_cnt 1.
- REQ-036: in_data 0x00000002, mode 01, pos_a 38 -> out_parity 7'b0000101, out_data 0x2, inj_cnt 1.
- REQ-037: in_data 0x0, mode 10, pos_a 0, pos_b 1 -> out_data 0x3, out_parity 0x00; downstream flags double error.
- REQ-038: Stream 5 words with out_ready low for 4 cycles mid-stream -> in_ready low after 2 accepts, all 5 words emitted in order, unchanged, out_cnt 5.
- REQ-039: Assert rst_n low with 2 words in flight -> out_valid 0 at once, counters 0, no stale word after release.
- REQ-040: CNT_W 2, 5 handshakes -> out_cnt saturates at 3; clr_cnt together with a handshake -> out_cnt 0.
